// File: rtl/exec_controller_pkg.sv
// Shared definitions for the execution sequencer: bus widths, UART command
// bytes, the HALT instruction word and the controller state encoding.
package exec_ctrl_pkg;

  localparam int unsigned NB_DATA      = 32;
  localparam int unsigned NB_BYTE      = 8;
  localparam int unsigned DEF_NB_ADDR  = 11;
  localparam int unsigned DEF_NB_CYCLE = 32;
  localparam int unsigned NB_STATE     = 3;

  localparam logic [NB_BYTE-1:0] CMD_LOAD  = 8'h4C;  // 'L'
  localparam logic [NB_BYTE-1:0] CMD_RUN   = 8'h43;  // 'C'
  localparam logic [NB_BYTE-1:0] CMD_STEP  = 8'h53;  // 'S'
  localparam logic [NB_BYTE-1:0] CMD_NEXT  = 8'h4E;  // 'N'
  localparam logic [NB_BYTE-1:0] CMD_ABORT = 8'h41;  // 'A'

  localparam logic [NB_DATA-1:0] HALT_INSTR = 32'hFFFF_FFFF;

  typedef enum logic [NB_STATE-1:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    READY     = 3'd2,
    RUN       = 3'd3,
    STEP_WAIT = 3'd4,
    STEP_EXEC = 3'd5,
    DONE      = 3'd6
  } state_t;

endpackage

// File: rtl/exec_controller_if.sv
// Bus between the UART/debug front-end, the pipeline and the sequencer.
// slave  : sequencer side (receives rx bytes and halt, drives memory/CPU control)
// master : front-end / pipeline side
interface exec_controller_if #(
  parameter int unsigned NB_ADDR  = 11,
  parameter int unsigned NB_CYCLE = 32
) ();
  import exec_ctrl_pkg::*;

  logic [NB_BYTE-1:0]  i_rx_data;
  logic                i_rx_valid;
  logic                i_halt;
  logic                o_mem_wr_en;
  logic [NB_ADDR-1:0]  o_mem_wr_addr;
  logic [NB_DATA-1:0]  o_mem_wr_data;
  logic                o_cpu_valid;
  logic                o_cpu_reset;
  logic [NB_CYCLE-1:0] o_cycle_count;
  logic                o_done;
  logic                o_load_error;
  logic [NB_STATE-1:0] o_state;

  modport slave (
    input  i_rx_data, i_rx_valid, i_halt,
    output o_mem_wr_en, o_mem_wr_addr, o_mem_wr_data, o_cpu_valid, o_cpu_reset,
           o_cycle_count, o_done, o_load_error, o_state
  );

  modport master (
    output i_rx_data, i_rx_valid, i_halt,
    input  o_mem_wr_en, o_mem_wr_addr, o_mem_wr_data, o_cpu_valid, o_cpu_reset,
           o_cycle_count, o_done, o_load_error, o_state
  );

endinterface

// File: rtl/exec_controller_word_assembler.sv
// Packs a big-endian byte stream into words.
// clock, reset : clock and synchronous active-high reset
// clear        : restart word alignment (start of a new load)
// byte_valid   : byte strobe, byte_data : the byte
// word_valid_c : combinational pulse on the strobe of the 4th byte of a word
// word_c       : the completed word, valid with word_valid_c
module word_assembler
  import exec_ctrl_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               clear,
  input  logic               byte_valid,
  input  logic [NB_BYTE-1:0] byte_data,
  output logic               word_valid_c,
  output logic [NB_DATA-1:0] word_c
);

  localparam int unsigned NB_SHIFT = NB_DATA - NB_BYTE;
  localparam int unsigned NB_CNT   = 2;

  logic [NB_CNT-1:0]   byte_cnt;
  logic [NB_SHIFT-1:0] shift;

  // Earlier bytes sit in the upper lanes; the live byte completes the word
  // without an extra register stage.
  assign word_c       = {shift, byte_data};
  assign word_valid_c = byte_valid && (byte_cnt == NB_CNT'(3));

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      byte_cnt <= '0;
      shift    <= '0;
    end else if (byte_valid) begin
      byte_cnt <= byte_cnt + NB_CNT'(1);
      shift    <= {shift[NB_SHIFT-NB_BYTE-1:0], byte_data};
    end
  end

endmodule

// File: rtl/exec_controller.sv
// Execution sequencer: loads program memory from the UART byte stream, then
// runs the pipeline continuously or single-stepped, counting enabled cycles.
// i_clock, i_reset : clock and synchronous active-high reset
// bus              : rx bytes, halt in; memory write port, cpu valid/reset,
//                    cycle count, done, load error and state out
module exec_controller
  import exec_ctrl_pkg::*;
#(
  parameter int unsigned NB_ADDR  = DEF_NB_ADDR,
  parameter int unsigned NB_CYCLE = DEF_NB_CYCLE
) (
  input  logic                i_clock,
  input  logic                i_reset,
  exec_controller_if.slave    bus
);

  state_t              state;
  logic [NB_ADDR-1:0]  addr;
  logic                cpu_valid;
  logic                cpu_reset;
  logic                mem_wr_en;
  logic [NB_ADDR-1:0]  mem_wr_addr;
  logic [NB_DATA-1:0]  mem_wr_data;
  logic [NB_CYCLE-1:0] cycle_count;
  logic                done;
  logic                load_error;

  logic                word_valid_c;
  logic [NB_DATA-1:0]  word_c;
  logic                cmd_state_c;
  logic                load_start_c;
  logic                asm_byte_valid_c;

  // States in which a new load may be started.
  assign cmd_state_c      = (state == IDLE) || (state == READY) || (state == DONE);
  assign load_start_c     = bus.i_rx_valid && (bus.i_rx_data == CMD_LOAD) && cmd_state_c;
  assign asm_byte_valid_c = bus.i_rx_valid && (state == LOAD);

  word_assembler u_word_assembler (
    .clock        (i_clock),
    .reset        (i_reset),
    .clear        (load_start_c),
    .byte_valid   (asm_byte_valid_c),
    .byte_data    (bus.i_rx_data),
    .word_valid_c (word_valid_c),
    .word_c       (word_c)
  );

  // Sequencer state machine with registered outputs.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state       <= IDLE;
      addr        <= '0;
      cpu_valid   <= 1'b0;
      cpu_reset   <= 1'b0;
      mem_wr_en   <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
      cycle_count <= '0;
      done        <= 1'b0;
      load_error  <= 1'b0;
    end else begin
      cpu_reset <= 1'b0;
      mem_wr_en <= 1'b0;
      done      <= 1'b0;
      cpu_valid <= 1'b0;

      // Count every enabled pipeline clock, saturating at all-ones.
      if (cpu_valid && (cycle_count != '1)) begin
        cycle_count <= cycle_count + NB_CYCLE'(1);
      end

      case (state)
        IDLE: begin
          if (load_start_c) begin
            state      <= LOAD;
            addr       <= '0;
            load_error <= 1'b0;
          end
        end

        LOAD: begin
          if (word_valid_c) begin
            mem_wr_en   <= 1'b1;
            mem_wr_addr <= addr;
            mem_wr_data <= word_c;
            addr        <= addr + NB_ADDR'(1);
            if (word_c == HALT_INSTR) begin
              state <= READY;
            end else if (addr == '1) begin
              // Memory full without a HALT word: stop rather than wrap.
              load_error <= 1'b1;
              state      <= READY;
            end
          end
        end

        READY, DONE: begin
          if (load_start_c) begin
            state      <= LOAD;
            addr       <= '0;
            load_error <= 1'b0;
          end else if (bus.i_rx_valid && (bus.i_rx_data == CMD_RUN)) begin
            cpu_reset   <= 1'b1;
            cycle_count <= '0;
            state       <= RUN;
          end else if (bus.i_rx_valid && (bus.i_rx_data == CMD_STEP)) begin
            cpu_reset   <= 1'b1;
            cycle_count <= '0;
            state       <= STEP_WAIT;
          end
        end

        RUN: begin
          // The first RUN clock has valid low (pipeline is in soft reset),
          // so halt is only honoured once the pipeline is enabled.
          if (cpu_valid && bus.i_halt) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            cpu_valid <= 1'b1;
          end
        end

        STEP_WAIT: begin
          if (bus.i_rx_valid && (bus.i_rx_data == CMD_NEXT)) begin
            state     <= STEP_EXEC;
            cpu_valid <= 1'b1;
          end else if (bus.i_rx_valid && (bus.i_rx_data == CMD_ABORT)) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end

        STEP_EXEC: begin
          if (bus.i_halt) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state <= STEP_WAIT;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_state       = state;
  assign bus.o_cpu_valid   = cpu_valid;
  assign bus.o_cpu_reset   = cpu_reset;
  assign bus.o_mem_wr_en   = mem_wr_en;
  assign bus.o_mem_wr_addr = mem_wr_addr;
  assign bus.o_mem_wr_data = mem_wr_data;
  assign bus.o_cycle_count = cycle_count;
  assign bus.o_done        = done;
  assign bus.o_load_error  = load_error;

endmodule
